// File: rtl/rx_frame_buffer.sv
// rx_frame_buffer: store-and-forward MAC rx buffer; rx_mac_* in, committed frames out on out_valid/out_ready/out_data/out_last, frames_ok/frames_dropped counters, overflow pulse
module rx_frame_buffer #(
  parameter int ADDR_W = 11,
  parameter int MAX_LEN = 1518,
  parameter int MIN_LEN = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_mac_valid,
  input  logic [7:0]  rx_mac_data,
  input  logic        rx_mac_last,
  input  logic        rx_mac_err,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  input  logic        out_ready,
  output logic [15:0] frames_ok,
  output logic [15:0] frames_dropped,
  output logic        overflow
);
  localparam logic [ADDR_W:0] depth = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ptr_one = 1;
  localparam logic [11:0] max_l = 12'(MAX_LEN);
  localparam logic [11:0] min_l = 12'(MIN_LEN);
  typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;
  state_t state;
  logic [8:0] ram [2**ADDR_W];
  logic [ADDR_W:0] wr_ptr, commit_ptr, rd_ptr;
  logic [11:0] len, len_n;
  logic err_sticky, err_n, beat, full, store, ok_inc, drop_inc, load;
  always_comb begin
    beat = rx_mac_valid && state != DROP;
    len_n = (state == IDLE ? 12'd0 : len) + 12'd1;
    err_n = (state == RECV && err_sticky) || rx_mac_err;
    full = wr_ptr - rd_ptr == depth;
    store = beat && !full && len_n <= max_l;
    ok_inc = store && rx_mac_last && !err_n && len_n >= min_l;
    drop_inc = rx_mac_valid && rx_mac_last && !ok_inc;
    load = rd_ptr != commit_ptr && (!out_valid || out_ready);
  end
  always_ff @(posedge clk)
    if (store) ram[wr_ptr[ADDR_W-1:0]] <= {rx_mac_last, rx_mac_data};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      wr_ptr <= '0;
      commit_ptr <= '0;
      rd_ptr <= '0;
      len <= '0;
      err_sticky <= 1'b0;
      out_valid <= 1'b0;
      out_data <= '0;
      out_last <= 1'b0;
      frames_ok <= '0;
      frames_dropped <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= beat && full;
      frames_ok <= frames_ok + 16'(ok_inc && frames_ok != 16'hffff);
      frames_dropped <= frames_dropped + 16'(drop_inc && frames_dropped != 16'hffff);
      if (rx_mac_valid) state <= rx_mac_last ? IDLE : store ? RECV : DROP;
      if (store) begin
        len <= len_n;
        err_sticky <= err_n;
      end
      // any abandoned frame rewinds the writer to the last commit point
      if (beat) wr_ptr <= store && (!rx_mac_last || ok_inc) ? wr_ptr + ptr_one : commit_ptr;
      if (ok_inc) commit_ptr <= wr_ptr + ptr_one;
      if (load) begin
        {out_last, out_data} <= ram[rd_ptr[ADDR_W-1:0]];
        rd_ptr <= rd_ptr + ptr_one;
      end
      out_valid <= load || (out_valid && !out_ready);
    end
  end
endmodule

// File: tb/tb_rx_frame_buffer.sv
// tb_rx_frame_buffer: randomized and directed checks of rx_frame_buffer against a frame-level queue model
module tb_rx_frame_buffer;
  localparam int DEPTH = 2048;
  localparam int MAX_LEN = 1518;
  localparam int MIN_LEN = 64;
  logic clk, reset, rx_mac_valid, rx_mac_last, rx_mac_err, out_ready;
  logic [7:0] rx_mac_data, out_data;
  logic out_valid, out_last, overflow;
  logic [15:0] frames_ok, frames_dropped;
  int checks = 0, errors = 0, exp_ok = 0, exp_drop = 0, ovf_cnt = 0, exp_ovf_tot = 0;
  logic [8:0] exp_q[$];
  logic [8:0] exp_b;

  rx_frame_buffer #(.ADDR_W(11), .MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN)) dut (
    .clk(clk), .reset(reset),
    .rx_mac_valid(rx_mac_valid), .rx_mac_data(rx_mac_data),
    .rx_mac_last(rx_mac_last), .rx_mac_err(rx_mac_err),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .frames_ok(frames_ok), .frames_dropped(frames_dropped), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) if (!reset) begin
    if (overflow) ovf_cnt++;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("extra_byte", 32'(out_valid), 32'd0);
      else begin
        exp_b = exp_q.pop_front();
        chk("out_byte", 32'({out_last, out_data}), 32'(exp_b));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // a frame is committed only if unflagged, MIN..MAX long and never hit a full buffer
  task automatic send(input int n, input int err_at, input bit seq, input bit rnd_rdy,
                      input bit partial, input int exp_ovf);
    logic [8:0] frame[$];
    logic [7:0] d;
    logic lst;
    int ovf_at = -1;
    for (int i = 0; i < n; i++) begin
      d = seq ? 8'(i) : 8'($urandom);
      lst = (i == n - 1) && !partial;
      rx_mac_valid = 1'b1;
      rx_mac_data = d;
      rx_mac_last = lst;
      rx_mac_err = (i == err_at);
      if (rnd_rdy) out_ready = ($urandom_range(3) != 0);
      frame.push_back({lst, d});
      tick();
      if (overflow && ovf_at < 0) ovf_at = i;
    end
    rx_mac_valid = 1'b0;
    rx_mac_last = 1'b0;
    rx_mac_err = 1'b0;
    chk("ovf_pos", ovf_at, exp_ovf);
    if (exp_ovf >= 0) exp_ovf_tot++;
    if (!partial) begin
      if (err_at < 0 && n >= MIN_LEN && n <= MAX_LEN && exp_ovf < 0) begin
        exp_ok++;
        foreach (frame[j]) exp_q.push_back(frame[j]);
      end else exp_drop++;
    end
  endtask

  task automatic idle(input int n, input bit rnd_rdy);
    for (int i = 0; i < n; i++) begin
      rx_mac_valid = 1'b0;
      rx_mac_last = 1'($urandom);
      rx_mac_err = 1'($urandom);
      rx_mac_data = 8'($urandom);
      if (rnd_rdy) out_ready = ($urandom_range(3) != 0);
      tick();
    end
    rx_mac_last = 1'b0;
    rx_mac_err = 1'b0;
  endtask

  task automatic drain(input string tag);
    int t = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && t < 5000) begin
      tick();
      t++;
    end
    repeat (3) tick();
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_idle"}, 32'(out_valid), 32'd0);
    chk({tag, "_ok"}, 32'(frames_ok), exp_ok);
    chk({tag, "_drop"}, 32'(frames_dropped), exp_drop);
    chk({tag, "_ovf"}, ovf_cnt, exp_ovf_tot);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"}, 32'(out_data), 32'd0);
    chk({tag, "_last"}, 32'(out_last), 32'd0);
    chk({tag, "_ok"}, 32'(frames_ok), 32'd0);
    chk({tag, "_drop"}, 32'(frames_dropped), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    rx_mac_valid = 1'b0;
    rx_mac_data = 8'd0;
    rx_mac_last = 1'b0;
    rx_mac_err = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk_zero("reset");
    // good 64-byte frame, first byte two cycles after the last beat
    out_ready = 1'b1;
    send(64, -1, 1, 0, 0, -1);
    chk("lat_c1", 32'(out_valid), 32'd0);
    tick();
    chk("lat_c2", 32'(out_valid), 32'd1);
    chk("first_byte", 32'(out_data), 32'd0);
    drain("good64");
    // errored frame followed by a good one
    send(100, 50, 0, 0, 0, -1);
    send(64, -1, 0, 0, 0, -1);
    drain("err100");
    // oversize then maximum size
    send(1519, -1, 0, 0, 0, -1);
    send(1518, -1, 0, 0, 0, -1);
    drain("maxlen");
    // runts
    send(63, -1, 0, 0, 0, -1);
    send(1, -1, 0, 0, 0, -1);
    drain("runt");
    // back-to-back 1500-byte frames with the reader stalled; the output register holds one byte beyond the RAM
    out_ready = 1'b0;
    send(1500, -1, 0, 0, 0, -1);
    send(1500, -1, 0, 0, 0, DEPTH + 1 - 1500);
    drain("overflow");
    send(64, -1, 0, 0, 0, -1);
    drain("after_ovf");
    // random traffic with random backpressure and ignored non-valid beats
    for (int k = 0; k < 25; k++) begin
      int n, e;
      n = $urandom_range(300, 1);
      e = ($urandom_range(7) == 0) ? $urandom_range(n - 1) : -1;
      send(n, e, 0, 1, 0, -1);
      idle(n, 1);
    end
    drain("random");
    // reset mid-readout and mid-frame
    out_ready = 1'b1;
    send(64, -1, 1, 0, 0, -1);
    send(30, -1, 0, 0, 1, -1);
    reset = 1'b1;
    exp_q.delete();
    tick();
    reset = 1'b0;
    exp_ok = 0;
    exp_drop = 0;
    ovf_cnt = 0;
    exp_ovf_tot = 0;
    chk_zero("midreset");
    tick();
    chk("post_reset_valid", 32'(out_valid), 32'd0);
    send(64, -1, 0, 0, 0, -1);
    drain("post_reset");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rx_frame_buffer.md
Name: rx_frame_buffer

Overview:
- Sits directly downstream of the MAC receive client interface (rx_mac_valid/rx_mac_data/rx_mac_last/rx_mac_error).
- Stores each incoming frame in an internal byte buffer and releases it to the bridge fabric only once the whole frame has arrived good.
- Discards frames flagged errored, oversize, runt, or overflowing the buffer, so downstream logic never sees a partial or bad frame.
- Presents committed frames on a valid/ready/last byte stream with backpressure.

Parameters:
- ADDR_W, 11, log2 of buffer depth in bytes (DEPTH = 2^ADDR_W = 2048).
- MAX_LEN, 1518, largest accepted frame length in bytes (longer frames are dropped).
- MIN_LEN, 64, smallest accepted frame length in bytes (shorter frames are dropped).

Ports:
- clk  input  1  single block clock; the MAC rx client clock is driven onto it.
- reset  input  1  synchronous, active-high reset.
- rx_mac_valid  input  1  receive byte strobe from the MAC.
- rx_mac_data  input  8  receive byte.
- rx_mac_last  input  1  marks the final byte of a frame; qualified by rx_mac_valid.
- rx_mac_err  input  1  frame error; any qualified beat asserting it taints the frame.
- out_valid  output  1  output byte valid.
- out_data  output  8  output byte.
- out_last  output  1  last byte of the committed frame.
- out_ready  input  1  downstream accept; a transfer occurs when out_valid && out_ready.
- frames_ok  output  16  count of committed frames, saturating at 0xFFFF.
- frames_dropped  output  16  count of discarded frames, saturating at 0xFFFF.
- overflow  output  1  one-cycle pulse when a frame is discarded because the buffer is full.

Behaviour:
- Storage: 9-bit × DEPTH RAM holding {last, data}. Pointers wr_ptr, commit_ptr and rd_ptr are each ADDR_W+1 bits and wrap modulo 2^(ADDR_W+1).
- Full condition: (wr_ptr − rd_ptr) == DEPTH.
- Reset state: all pointers 0, writer in IDLE, output register empty. out_valid=0, out_data=0, out_last=0, frames_ok=0, frames_dropped=0, overflow=0.
- Beats with rx_mac_valid=0 are ignored. The block has no backpressure towards the MAC.
- Writer FSM:
  - IDLE: a valid beat writes RAM[wr_ptr], increments wr_ptr, sets len=1, latches err_sticky=rx_mac_err, and moves to RECV. If that beat also has last=1, apply end-of-frame rules immediately (the frame is a runt, so it is dropped).
  - RECV: each valid beat writes, increments wr_ptr and len, and ORs rx_mac_err into err_sticky.
    - If the buffer is full when a beat arrives: do not write, wr_ptr <= commit_ptr, pulse overflow, go to DROP. If that beat is also last, count it as dropped and go to IDLE.
    - If len would exceed MAX_LEN: wr_ptr <= commit_ptr, go to DROP.
  - End of frame (valid && last in RECV): frame is good if err_sticky|rx_mac_err == 0 and MIN_LEN ≤ len ≤ MAX_LEN.
    - Good: the last byte is stored with its last bit set, commit_ptr <= wr_ptr+1, frames_ok++.
    - Bad: wr_ptr <= commit_ptr, frames_dropped++.
    - Next state is IDLE in both cases.
  - DROP: beats are discarded. On a valid last beat, frames_dropped++ and go to IDLE. frames_dropped is incremented exactly once per discarded frame.
- Reader:
  - A single-entry output register is loaded from RAM[rd_ptr] (rd_ptr++) whenever rd_ptr != commit_ptr and the register is empty or being consumed this cycle. This sustains 1 byte/clk under continuous out_ready.
  - Latency: the first byte of a frame is presented on out_valid 2 cycles after the cycle its last beat is accepted, when the output register is empty.
  - out_data and out_last hold stable while out_valid && !out_ready.
  - Uncommitted bytes are never read.
- Concurrency: simultaneous write, commit and read in one cycle are legal. Full is evaluated against the registered rd_ptr; space freed in the same cycle becomes visible next cycle.
- Reset mid-frame: buffered and partial frames are lost and the writer returns to IDLE. The next valid beat is treated as a frame start; upstream is reset in the same domain.
- Counters saturate; they do not wrap.

Test Plan:
- 64-byte good frame, bytes 0x00..0x3F, out_ready=1 → out_valid 2 cycles after the last beat; 64 consecutive bytes 0x00..0x3F with out_last on 0x3F; frames_ok=1.
- 100-byte frame with rx_mac_err on byte 50, then a good 64-byte frame → only the 64-byte frame is output; frames_dropped=1, frames_ok=1; wr_ptr equals commit_ptr after the first frame.
- 1519-byte frame, then a 1518-byte frame → first dropped with no output; second output intact with 1518 bytes.
- 63-byte frame and a 1-byte frame (last on the first beat) → both dropped; frames_dropped=2, no output.
- out_ready=0, feed 1500-byte frames back to back → first frame committed; second overflows at byte 549 with a single overflow pulse; frames_dropped=1. Then raise out_ready → the first frame is output intact, and the next frame after space frees is accepted.
- Reset asserted mid-frame and mid-readout → all outputs and counters are 0 on the next cycle; a following 64-byte frame passes correctly.
